// File: rtl/code_entry_lock.sv
// code_entry_lock
//   Sequential code-entry front-end. The user sets a 4-bit digit on the
//   switches and presses the enter button once per digit. A complete
//   sequence is compared against CODE. The block drives unlock, fail and
//   lockout status, plus a seven-segment echo of the last accepted digit.
//
// Ports
//   clk          system clock
//   reset        synchronous, active-high reset
//   key_n        raw enter push-button, active-low, asynchronous to clk
//   digit[3:0]   raw digit switches, asynchronous to clk
//   clr          synchronous abort of the current entry
//   unlocked     high while in UNLOCKED
//   fail         one-cycle pulse on a wrong complete code
//   locked_out   high while in LOCKOUT
//   digit_count  digits entered in the current attempt
//   hex_out      active-low segments (bit0 = a .. bit6 = g) of last digit
//
// State table
//   ENTRY    | collecting digits of an attempt
//   UNLOCKED | correct code entered, waiting for enter/clr to relock
//   LOCKOUT  | too many consecutive failures, inputs ignored until timeout
module code_entry_lock #(
  parameter int                      NUM_DIGITS     = 2,
  parameter logic [4*NUM_DIGITS-1:0] CODE           = 'h62,
  parameter int                      MAX_FAILS      = 3,
  parameter int                      LOCKOUT_CYCLES = 50
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_n,
  input  logic [3:0] digit,
  input  logic       clr,
  output logic       unlocked,
  output logic       fail,
  output logic       locked_out,
  output logic [3:0] digit_count,
  output logic [6:0] hex_out
);

  localparam int         TW    = $clog2(LOCKOUT_CYCLES + 1);
  localparam logic [6:0] BLANK = 7'b1111111;

  typedef enum logic [1:0] {ENTRY, UNLOCKED, LOCKOUT} state_t;

  state_t          state, state_n;
  logic            k1, k2, k3;
  logic [3:0]      d1, d2;
  logic [2:0]      idx, idx_n;
  logic            mismatch, mismatch_n;
  logic [3:0]      fail_cnt, fail_cnt_n, fail_inc;
  logic [TW-1:0]   timer, timer_n;
  logic [6:0]      hex_n;
  logic            fail_n;
  logic            enter;
  logic [3:0]      code_dig;
  logic            dig_ok;

  function automatic logic [6:0] seg(input logic [3:0] v);
    case (v)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
  endfunction

  // k3 is the older sample, so a high-to-low transition on the button
  // shows up as k3=1, k2=0 for exactly one cycle.
  assign enter    = k3 & ~k2;
  assign code_dig = 4'(CODE >> {idx, 2'b00});
  assign dig_ok   = (d2 == code_dig);
  assign fail_inc = fail_cnt + 4'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      k1       <= 1'b1;
      k2       <= 1'b1;
      k3       <= 1'b1;
      d1       <= 4'd0;
      d2       <= 4'd0;
      state    <= ENTRY;
      idx      <= 3'd0;
      mismatch <= 1'b0;
      fail_cnt <= 4'd0;
      timer    <= '0;
      hex_out  <= BLANK;
      fail     <= 1'b0;
    end else begin
      k1       <= key_n;
      k2       <= k1;
      k3       <= k2;
      d1       <= digit;
      d2       <= d1;
      state    <= state_n;
      idx      <= idx_n;
      mismatch <= mismatch_n;
      fail_cnt <= fail_cnt_n;
      timer    <= timer_n;
      hex_out  <= hex_n;
      fail     <= fail_n;
    end
  end

  always_comb begin
    state_n    = state;
    idx_n      = idx;
    mismatch_n = mismatch;
    fail_cnt_n = fail_cnt;
    timer_n    = timer;
    hex_n      = hex_out;
    fail_n     = 1'b0;
    case (state)
      ENTRY: begin
        if (clr) begin
          idx_n      = 3'd0;
          mismatch_n = 1'b0;
          hex_n      = BLANK;
        end else if (enter) begin
          hex_n = seg(d2);
          if (idx == 3'(NUM_DIGITS - 1)) begin
            idx_n      = 3'd0;
            mismatch_n = 1'b0;
            if (!mismatch && dig_ok) begin
              state_n    = UNLOCKED;
              fail_cnt_n = 4'd0;
            end else begin
              fail_n     = 1'b1;
              fail_cnt_n = fail_inc;
              if (fail_inc == 4'(MAX_FAILS)) begin
                state_n = LOCKOUT;
                timer_n = TW'(LOCKOUT_CYCLES);
              end
            end
          end else begin
            mismatch_n = mismatch | ~dig_ok;
            idx_n      = idx + 3'd1;
          end
        end
      end
      UNLOCKED: begin
        if (enter || clr) begin
          state_n    = ENTRY;
          idx_n      = 3'd0;
          mismatch_n = 1'b0;
          hex_n      = BLANK;
        end
      end
      LOCKOUT: begin
        if (timer == TW'(1)) begin
          state_n    = ENTRY;
          fail_cnt_n = 4'd0;
          timer_n    = '0;
        end else begin
          timer_n = timer - TW'(1);
        end
      end
      default: state_n = ENTRY;
    endcase
  end

  assign unlocked    = (state == UNLOCKED);
  assign locked_out  = (state == LOCKOUT);
  assign digit_count = {1'b0, idx};

endmodule

// File: tb/tb_code_entry_lock.sv
module tb_code_entry_lock;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       key_n = 1'b1;
  logic [3:0] digit = 4'd0;
  logic       clr = 1'b0;
  logic       unlocked, fail, locked_out;
  logic [3:0] digit_count;
  logic [6:0] hex_out;

  localparam logic [6:0] BLANK = 7'b1111111;
  localparam logic [6:0] SEG1  = 7'b1111001;
  localparam logic [6:0] SEG2  = 7'b0100100;
  localparam logic [6:0] SEG3  = 7'b0110000;
  localparam logic [6:0] SEG6  = 7'b0000010;

  typedef struct {
    logic [13:0] v;
    int          gap;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  bit   mon_en = 1'b0;
  bit   primed = 1'b0;
  int   cyc = 0;
  int   last_cyc = 0;
  logic [13:0] prev_v;

  code_entry_lock dut (
    .clk(clk), .reset(reset), .key_n(key_n), .digit(digit), .clr(clr),
    .unlocked(unlocked), .fail(fail), .locked_out(locked_out),
    .digit_count(digit_count), .hex_out(hex_out)
  );

  always #5 clk = ~clk;

  wire [13:0] outv = {unlocked, fail, locked_out, digit_count, hex_out};

  function automatic logic [13:0] mk(bit u, bit f, bit l, logic [3:0] c, logic [6:0] h);
    return {u, f, l, c, h};
  endfunction

  task automatic push(input logic [13:0] v, input int gap);
    exp_t e;
    e.v = v;
    e.gap = gap;
    q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [13:0] got, input logic [13:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // Monitor: every change of the output vector is one DUT response.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (mon_en) begin
      if (!primed) begin
        prev_v = outv;
        primed = 1'b1;
        last_cyc = cyc;
      end else if (outv !== prev_v) begin
        tests++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_change: got %h want no change", outv);
        end else begin
          e = q.pop_front();
          if (outv !== e.v) begin
            fails++;
            $display("FAIL out_vector: got %h want %h", outv, e.v);
          end
          if (e.gap >= 0) begin
            tests++;
            if (cyc - last_cyc != e.gap) begin
              fails++;
              $display("FAIL change_gap: got %0d want %0d", cyc - last_cyc, e.gap);
            end
          end
        end
        prev_v = outv;
        last_cyc = cyc;
      end
    end
  end

  task automatic press(input logic [3:0] d, input int hold);
    @(negedge clk) digit = d;
    repeat (3) @(negedge clk);
    key_n = 1'b0;
    repeat (hold) @(negedge clk);
    key_n = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;
  endtask

  // one wrong (1,1) attempt that does not reach lockout; hex shows the last digit
  task automatic wrong_attempt();
    push(mk(0, 0, 0, 1, SEG1), -1);
    push(mk(0, 1, 0, 0, SEG1), -1);
    push(mk(0, 0, 0, 0, SEG1), 1);
    press(4'd1, 1);
    press(4'd1, 1);
  endtask

  // wrong (1,1) attempt that triggers lockout
  task automatic lockout_attempt();
    push(mk(0, 0, 0, 1, SEG1), -1);
    push(mk(0, 1, 1, 0, SEG1), -1);
    push(mk(0, 0, 1, 0, SEG1), 1);
    press(4'd1, 1);
    press(4'd1, 1);
  endtask

  task automatic unlock_seq();
    push(mk(0, 0, 0, 1, SEG2), -1);
    push(mk(1, 0, 0, 0, SEG6), -1);
    press(4'd2, 1);
    press(4'd6, 1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_state", outv, mk(0, 0, 0, 0, BLANK));
    reset = 1'b0;
    @(negedge clk);
    mon_en = 1'b1;
    @(negedge clk);

    // correct code with explicit unlock latency
    push(mk(0, 0, 0, 1, SEG2), -1);
    press(4'd2, 1);
    push(mk(1, 0, 0, 0, SEG6), -1);
    @(negedge clk) digit = 4'd6;
    repeat (3) @(negedge clk);
    key_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 chk("unlock_latency_e1", {13'd0, unlocked}, 14'd0);
    @(posedge clk);
    #1 chk("unlock_latency_e2", {13'd0, unlocked}, 14'd1);
    @(negedge clk) key_n = 1'b1;
    repeat (10) @(negedge clk);

    // press in UNLOCKED relocks; then wrong first digit
    push(mk(0, 0, 0, 0, BLANK), -1);
    press(4'd9, 1);
    push(mk(0, 0, 0, 1, SEG3), -1);
    push(mk(0, 1, 0, 0, SEG6), -1);
    push(mk(0, 0, 0, 0, SEG6), 1);
    press(4'd3, 1);
    press(4'd6, 1);

    // clean fail count, then lockout with presses ignored
    push(mk(0, 0, 0, 0, BLANK), -1);
    do_reset();
    repeat (3) @(negedge clk);
    wrong_attempt();
    wrong_attempt();
    lockout_attempt();
    push(mk(0, 0, 0, 0, SEG1), 49);
    press(4'd2, 1);
    press(4'd6, 1);
    repeat (30) @(negedge clk);
    unlock_seq();

    // held press from ENTRY gives one digit only
    push(mk(0, 0, 0, 0, BLANK), -1);
    press(4'd5, 1);
    push(mk(0, 0, 0, 1, SEG2), -1);
    press(4'd2, 20);
    repeat (20) @(negedge clk);
    chk("held_press_count", {10'd0, digit_count}, 14'd1);
    push(mk(0, 0, 0, 0, BLANK), -1);
    @(negedge clk) clr = 1'b1;
    @(negedge clk) clr = 1'b0;
    repeat (5) @(negedge clk);

    // clr coincident with the enter pulse wins
    push(mk(0, 0, 0, 1, SEG2), -1);
    press(4'd2, 1);
    push(mk(0, 0, 0, 0, BLANK), -1);
    @(negedge clk) digit = 4'd6;
    repeat (3) @(negedge clk);
    key_n = 1'b0;
    @(posedge clk);
    @(negedge clk) key_n = 1'b1;
    @(posedge clk);
    @(negedge clk) clr = 1'b1;
    @(negedge clk) clr = 1'b0;
    repeat (10) @(negedge clk);
    chk("clr_wins_count", {10'd0, digit_count}, 14'd0);
    unlock_seq();

    // reset during lockout
    push(mk(0, 0, 0, 0, BLANK), -1);
    press(4'd0, 1);
    wrong_attempt();
    wrong_attempt();
    lockout_attempt();
    repeat (10) @(negedge clk);
    push(mk(0, 0, 0, 0, BLANK), -1);
    do_reset();
    chk("reset_in_lockout", outv, mk(0, 0, 0, 0, BLANK));
    repeat (5) @(negedge clk);

    // reset mid-attempt, then fail_cnt must need three more failures
    push(mk(0, 0, 0, 1, SEG2), -1);
    press(4'd2, 1);
    push(mk(0, 0, 0, 0, BLANK), -1);
    do_reset();
    chk("reset_mid_attempt", outv, mk(0, 0, 0, 0, BLANK));
    repeat (3) @(negedge clk);
    wrong_attempt();
    wrong_attempt();
    lockout_attempt();
    push(mk(0, 0, 0, 0, SEG1), 49);
    repeat (60) @(negedge clk);

    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL pending_expect: got %0d left want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

endmodule
